vcve2_multdiv_arbiter: RTL

VCVE2_MULTDIV_ARBITER -- requirements
Module: vcve2_multdiv_arbiter

---
 rtl/vcve2_multdiv_arbiter_if.sv | 42 ++++
 rtl/vcve2_multdiv_arbiter.sv | 101 ++++++++++
 2 files changed

// File: rtl/vcve2_multdiv_arbiter_if.sv
// Requester-side and multiplier/divider-side signals of the two-port multdiv arbiter.
// slave is the arbiter's view; master is the requesters/multdiv-unit view.
interface vcve2_multdiv_arbiter_if;
    logic [1:0]           req_i;
    logic [1:0][1:0]      operator_i;
    logic [1:0][1:0]      signed_mode_i;
    logic [1:0][31:0]     op_a_i;
    logic [1:0][31:0]     op_b_i;
    logic [1:0]           flush_i;
    logic [1:0]           gnt_o;
    logic [1:0]           rvalid_o;
    logic [1:0]           rready_i;
    logic [31:0]          rdata_o;

    logic                 md_mult_en_o;
    logic                 md_div_en_o;
    logic                 md_mult_sel_o;
    logic                 md_div_sel_o;
    logic [1:0]           md_operator_o;
    logic [1:0]           md_signed_mode_o;
    logic [31:0]          md_op_a_o;
    logic [31:0]          md_op_b_o;
    logic                 md_ready_id_o;
    logic                 md_valid_i;
    logic [31:0]          md_result_i;

    modport slave (
        input  req_i, operator_i, signed_mode_i, op_a_i, op_b_i, flush_i, rready_i,
        input  md_valid_i, md_result_i,
        output gnt_o, rvalid_o, rdata_o,
        output md_mult_en_o, md_div_en_o, md_mult_sel_o, md_div_sel_o,
        output md_operator_o, md_signed_mode_o, md_op_a_o, md_op_b_o, md_ready_id_o
    );

    modport master (
        output req_i, operator_i, signed_mode_i, op_a_i, op_b_i, flush_i, rready_i,
        output md_valid_i, md_result_i,
        input  gnt_o, rvalid_o, rdata_o,
        input  md_mult_en_o, md_div_en_o, md_mult_sel_o, md_div_sel_o,
        input  md_operator_o, md_signed_mode_o, md_op_a_o, md_op_b_o, md_ready_id_o
    );
endinterface

// File: rtl/vcve2_multdiv_arbiter.sv
// Two-port arbiter sharing one slow multiplier/divider; one operation in flight at a time.
// Define VCVE2_MDARB_RR_EN for round-robin arbitration (default: port 0 fixed priority).
module vcve2_multdiv_arbiter (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    vcve2_multdiv_arbiter_if.slave bus
);
    typedef enum logic [1:0] {MD_OP_MULL, MD_OP_MULH, MD_OP_DIV, MD_OP_REM} md_op_e;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    state_e      state_q;
    md_op_e      operator_q;
    logic [1:0]  signed_mode_q;
    logic [31:0] op_a_q;
    logic [31:0] op_b_q;
    logic [31:0] result_q;
    logic        owner_q;
    logic        discard_q;
    logic        any_req;
    logic        winner;
    logic        owner_flush;

    assign any_req     = |bus.req_i;
    assign owner_flush = bus.flush_i[owner_q];

`ifdef VCVE2_MDARB_RR_EN
    logic ptr_q;

    // ptr_q names the preferred port; the other port wins only when ptr_q is not requesting.
    always_comb winner = bus.req_i[ptr_q] ? ptr_q : ~ptr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                          ptr_q <= 1'b0;
        else if (state_q == IDLE && any_req)  ptr_q <= ~winner;
    end
`else
    assign winner = ~bus.req_i[0];
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            operator_q    <= MD_OP_MULL;
            signed_mode_q <= 2'b00;
            op_a_q        <= 32'h0;
            op_b_q        <= 32'h0;
            result_q      <= 32'h0;
            owner_q       <= 1'b0;
            discard_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (any_req) begin
                    operator_q    <= md_op_e'(bus.operator_i[winner]);
                    signed_mode_q <= bus.signed_mode_i[winner];
                    op_a_q        <= bus.op_a_i[winner];
                    op_b_q        <= bus.op_b_i[winner];
                    owner_q       <= winner;
                    discard_q     <= 1'b0;
                    state_q       <= BUSY;
                end
                BUSY: begin
                    // A killed operation still runs to completion so the unit ends idle.
                    if (bus.md_valid_i) begin
                        discard_q <= 1'b0;
                        if (discard_q || owner_flush) begin
                            state_q <= IDLE;
                        end else begin
                            result_q <= bus.md_result_i;
                            state_q  <= RESP;
                        end
                    end else if (owner_flush) begin
                        discard_q <= 1'b1;
                    end
                end
                RESP: if (bus.rready_i[owner_q] || owner_flush) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.gnt_o = 2'b00;
        if (state_q == IDLE && any_req && rst_ni) bus.gnt_o[winner] = 1'b1;
    end

    always_comb begin
        bus.rvalid_o = 2'b00;
        if (state_q == RESP && !owner_flush) bus.rvalid_o[owner_q] = 1'b1;
    end

    assign bus.rdata_o          = (state_q == RESP) ? result_q : 32'h0;
    assign bus.md_mult_en_o     = (state_q == BUSY) && !operator_q[1];
    assign bus.md_mult_sel_o    = (state_q == BUSY) && !operator_q[1];
    assign bus.md_div_en_o      = (state_q == BUSY) &&  operator_q[1];
    assign bus.md_div_sel_o     = (state_q == BUSY) &&  operator_q[1];
    assign bus.md_ready_id_o    = (state_q == BUSY);
    assign bus.md_operator_o    = operator_q;
    assign bus.md_signed_mode_o = signed_mode_q;
    assign bus.md_op_a_o        = op_a_q;
    assign bus.md_op_b_o        = op_b_q;
endmodule
